// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The optional round-robin mode is selected with RF_ARB_ROUND_ROBIN_EN.
package rf_arb_pkg;

    typedef logic [3:0] reg_addr_t;

    // R15 is the program counter; writes to it are accepted and then dropped.
    localparam reg_addr_t PC_REG = 4'd15;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the writeback requesters, decode reservation/check ports and the
// register-file write drive. Macro RF_ARB_ROUND_ROBIN_EN does not change it.
interface rf_write_arbiter_if #(
    parameter int N = 32
);

    // Handshake: a transfer happens in a cycle where valid and ready are both 1.
    // The requester holds valid/addr/data stable until then; ready is
    // combinational and never depends on a transfer having already happened.
    logic                   alu_valid;
    logic                   alu_ready;
    rf_arb_pkg::reg_addr_t  alu_addr;
    logic [N-1:0]           alu_data;

    logic                   mem_valid;
    logic                   mem_ready;
    rf_arb_pkg::reg_addr_t  mem_addr;
    logic [N-1:0]           mem_data;

    logic                   rsv_valid;
    rf_arb_pkg::reg_addr_t  rsv_addr;
    rf_arb_pkg::reg_addr_t  chk_a1;
    rf_arb_pkg::reg_addr_t  chk_a2;
    logic                   stall;
    logic                   flush;

    logic                   we3;
    rf_arb_pkg::reg_addr_t  a3;
    logic [N-1:0]           wd3;
    logic                   err_r15;

    rf_arb_pkg::arb_state_t state_dbg;
    logic [14:0]            pending_dbg;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output rsv_valid, rsv_addr, chk_a1, chk_a2, flush,
        input  alu_ready, mem_ready, stall,
        input  we3, a3, wd3, err_r15, state_dbg, pending_dbg
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  rsv_valid, rsv_addr, chk_a1, chk_a2, flush,
        output alu_ready, mem_ready, stall,
        output we3, a3, wd3, err_r15, state_dbg, pending_dbg
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: decode reservations set bits, register-file
// writes clear them, and a source hit on a pending bit raises stall.
module rf_scoreboard
    import rf_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rsv_en,
    input  reg_addr_t   rsv_addr,
    input  logic        clr_en,
    input  reg_addr_t   clr_addr,
    input  logic        clear_all,
    input  reg_addr_t   chk_a1,
    input  reg_addr_t   chk_a2,
    output logic        stall,
    output logic [14:0] pending
);

    logic [14:0] set_mask;
    logic [14:0] clr_mask;
    logic [15:0] pend16;

    assign set_mask = (rsv_en && rsv_addr != PC_REG) ? (15'd1 << rsv_addr) : 15'd0;
    assign clr_mask = (clr_en && clr_addr != PC_REG) ? (15'd1 << clr_addr) : 15'd0;

    // A reservation landing on the same edge as the retiring write keeps the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (clear_all) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // Bit 15 is tied low so R15 can never stall decode.
    assign pend16 = {1'b0, pending};
    assign stall  = pend16[chk_a1] | pend16[chk_a2];

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port and
// tracks pending destinations. Define RF_ARB_ROUND_ROBIN_EN for alternating contention grants.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N = 32
) (
    input logic              clk,
    input logic              rst,
    rf_write_arbiter_if.slave bus
);

    arb_state_t   state, state_nx;
    req_t         prefer, winner;
    logic         contended, open, xfer, drain_done;
    logic         alu_rdy, mem_rdy;
    reg_addr_t    win_addr;
    logic [N-1:0] win_data;
    logic         we3_q, err_q;
    reg_addr_t    a3_q;
    logic [N-1:0] wd3_q;
    logic         stall_w;
    logic [14:0]  pending_w;

    assign contended = bus.alu_valid & bus.mem_valid;

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (xfer && contended) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    assign prefer = rr_ptr ? REQ_MEM : REQ_ALU;
`else
    assign prefer = REQ_MEM;
`endif

    always_comb begin
        winner = REQ_ALU;
        if (contended) begin
            winner = prefer;
        end else if (bus.mem_valid) begin
            winner = REQ_MEM;
        end
    end

    // Requesters are shut out while draining and while reset is held.
    assign open    = (state == RUN) && !rst;
    assign alu_rdy = open && bus.alu_valid && (winner == REQ_ALU);
    assign mem_rdy = open && bus.mem_valid && (winner == REQ_MEM);
    assign xfer    = alu_rdy | mem_rdy;

    assign win_addr = mem_rdy ? bus.mem_addr : bus.alu_addr;
    assign win_data = mem_rdy ? bus.mem_data : bus.alu_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        drain_done = 1'b0;
        case (state)
            RUN: begin
                if (bus.flush) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!we3_q) begin
                    state_nx   = RUN;
                    drain_done = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_q <= 1'b0;
            err_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= xfer && (win_addr != PC_REG);
            err_q <= xfer && (win_addr == PC_REG);
            if (xfer && win_addr != PC_REG) begin
                a3_q  <= win_addr;
                wd3_q <= win_data;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rsv_en    (bus.rsv_valid && state == RUN),
        .rsv_addr  (bus.rsv_addr),
        .clr_en    (we3_q),
        .clr_addr  (a3_q),
        .clear_all (drain_done),
        .chk_a1    (bus.chk_a1),
        .chk_a2    (bus.chk_a2),
        .stall     (stall_w),
        .pending   (pending_w)
    );

    assign bus.alu_ready   = alu_rdy;
    assign bus.mem_ready   = mem_rdy;
    assign bus.we3         = we3_q;
    assign bus.a3          = a3_q;
    assign bus.wd3         = wd3_q;
    assign bus.err_r15     = err_q;
    assign bus.stall       = stall_w;
    assign bus.state_dbg   = state;
    assign bus.pending_dbg = pending_w;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: expected register-file writes are queued as
// stimulus is driven and matched against we3/a3/wd3 by a negedge monitor.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.N(N)) bus ();

  rf_write_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [4+N-1:0] exp_q[$];
  logic [4+N-1:0] exp_w;
  bit mon_en = 1'b0;
  bit rr_ptr_m = 1'b0;

  // Write monitor: every we3 pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (mon_en && !rst && bus.we3 !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write we3=%b a3=%0d wd3=%h, required no write", bus.we3, bus.a3, bus.wd3);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus.a3, bus.wd3} !== exp_w) begin
          errors++;
          $display("FAIL write_data got a3=%0d wd3=%h, required a3=%0d wd3=%h", bus.a3, bus.wd3, exp_w[N+3:N], exp_w[N-1:0]);
        end
      end
    end
  end

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.rsv_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic alu_write(input reg_addr_t a, input logic [N-1:0] d);
    @(posedge clk); #1;
    bus.alu_valid = 1'b1; bus.alu_addr = a; bus.alu_data = d;
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      errors++; $display("FAIL alu_write_ready got %b required 1", bus.alu_ready);
    end
    exp_q.push_back({a, d});
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd1; bus.alu_data = '0;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd2; bus.mem_data = '0;
    bus.rsv_addr = 4'd0; bus.chk_a1 = 4'd0; bus.chk_a2 = 4'd0;
    rst = 1'b1;
    rr_ptr_m = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.we3, bus.a3, bus.wd3, bus.err_r15} !== '0) begin
      errors++; $display("FAIL reset_outputs got we3=%b a3=%0d wd3=%h err=%b required all 0", bus.we3, bus.a3, bus.wd3, bus.err_r15);
    end
    checks++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b%b required 00", bus.alu_ready, bus.mem_ready);
    end
    checks++;
    if (bus.stall !== 1'b0 || bus.state_dbg !== RUN) begin
      errors++; $display("FAIL reset_stall_state got stall=%b state=%0d required 0/RUN", bus.stall, bus.state_dbg);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_write();
    alu_write(4'd3, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (bus.we3 !== 1'b1 || bus.a3 !== 4'd3) begin
      errors++; $display("FAIL single_we3 got we3=%b a3=%0d required 1/3", bus.we3, bus.a3);
    end
  endtask

  task automatic test_contention();
    reg_addr_t alu_a[3];
    reg_addr_t mem_a[3];
    logic [N-1:0] alu_d[3];
    logic [N-1:0] mem_d[3];
    int ai, mi;
    bit both, w_mem, exp_alu;
    alu_a = '{4'd1, 4'd3, 4'd6};
    mem_a = '{4'd2, 4'd4, 4'd7};
    for (int i = 0; i < 3; i++) begin
      alu_d[i] = $urandom();
      mem_d[i] = $urandom();
    end
    ai = 0; mi = 0;
    @(posedge clk); #1;
    bus.alu_valid = 1'b1; bus.alu_addr = alu_a[0]; bus.alu_data = alu_d[0];
    bus.mem_valid = 1'b1; bus.mem_addr = mem_a[0]; bus.mem_data = mem_d[0];
    while (ai < 3 || mi < 3) begin
      @(negedge clk);
      both = bus.alu_valid && bus.mem_valid;
`ifdef RF_ARB_ROUND_ROBIN_EN
      w_mem = both ? rr_ptr_m : bus.mem_valid;
`else
      w_mem = bus.mem_valid;
`endif
      exp_alu = bus.alu_valid && !w_mem;
      checks++;
      if (bus.alu_ready !== exp_alu || bus.mem_ready !== w_mem) begin
        errors++; $display("FAIL contention_grant got alu=%b mem=%b required alu=%b mem=%b", bus.alu_ready, bus.mem_ready, exp_alu, w_mem);
      end
      if (w_mem) exp_q.push_back({mem_a[mi], mem_d[mi]});
      else       exp_q.push_back({alu_a[ai], alu_d[ai]});
      if (both) rr_ptr_m = ~rr_ptr_m;
      @(posedge clk); #1;
      if (w_mem) begin
        mi++;
        if (mi < 3) begin bus.mem_addr = mem_a[mi]; bus.mem_data = mem_d[mi]; end
        else bus.mem_valid = 1'b0;
      end else begin
        ai++;
        if (ai < 3) begin bus.alu_addr = alu_a[ai]; bus.alu_data = alu_d[ai]; end
        else bus.alu_valid = 1'b0;
      end
    end
    idle();
  endtask

  task automatic test_hazard();
    @(posedge clk); #1;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd5; bus.chk_a1 = 4'd5; bus.chk_a2 = 4'd0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL hazard_before_set got %b required 0", bus.stall); end
    @(posedge clk); #1;
    bus.rsv_valid = 1'b0; bus.chk_a1 = 4'd0; bus.chk_a2 = 4'd5;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL hazard_a2 got %b required 1", bus.stall); end
    @(posedge clk); #1;
    bus.chk_a1 = 4'd5; bus.chk_a2 = 4'd15;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 32'h0000_0055;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1 || bus.alu_ready !== 1'b1) begin
      errors++; $display("FAIL hazard_xfer got stall=%b ready=%b required 1/1", bus.stall, bus.alu_ready);
    end
    exp_q.push_back({4'd5, 32'h0000_0055});
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL hazard_during_we3 got %b required 1", bus.stall); end
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL hazard_cleared got %b required 0", bus.stall); end
    // Re-reserve 5 on the very edge that retires the next write to 5.
    @(posedge clk); #1;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd5;
    @(posedge clk); #1;
    bus.rsv_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 32'h0000_0066;
    @(negedge clk);
    exp_q.push_back({4'd5, 32'h0000_0066});
    @(posedge clk); #1;
    bus.alu_valid = 1'b0; bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd5;
    @(posedge clk); #1;
    bus.rsv_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL hazard_set_wins got %b required 1", bus.stall); end
    alu_write(4'd5, 32'h0000_0077);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL hazard_final got %b required 0", bus.stall); end
  endtask

  task automatic test_r15();
    @(posedge clk); #1;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd9; bus.chk_a1 = 4'd9; bus.chk_a2 = 4'd15;
    @(posedge clk); #1;
    bus.rsv_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd15; bus.mem_data = $urandom();
    @(negedge clk);
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.stall !== 1'b1) begin
      errors++; $display("FAIL r15_accept got ready=%b stall=%b required 1/1", bus.mem_ready, bus.stall);
    end
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err_r15 !== 1'b1 || bus.we3 !== 1'b0 || bus.stall !== 1'b1) begin
      errors++; $display("FAIL r15_err got err=%b we3=%b stall=%b required 1/0/1", bus.err_r15, bus.we3, bus.stall);
    end
    @(negedge clk);
    checks++;
    if (bus.err_r15 !== 1'b0) begin errors++; $display("FAIL r15_pulse_len got %b required 0", bus.err_r15); end
    @(posedge clk); #1;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd15; bus.chk_a1 = 4'd15;
    @(posedge clk); #1;
    bus.rsv_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL r15_no_stall got %b required 0", bus.stall); end
    alu_write(4'd9, 32'h0000_0099);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd4;
    @(posedge clk); #1;
    bus.rsv_addr = 4'd7;
    @(posedge clk); #1;
    bus.rsv_valid = 1'b0; bus.chk_a1 = 4'd4; bus.chk_a2 = 4'd7;
    bus.flush = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 32'h0000_0022;
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.stall !== 1'b1) begin
      errors++; $display("FAIL flush_cycle got ready=%b stall=%b required 1/1", bus.alu_ready, bus.stall);
    end
    exp_q.push_back({4'd2, 32'h0000_0022});
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.alu_addr = 4'd6; bus.alu_data = 32'h0000_0066;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd8;
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b0 || bus.state_dbg !== DRAIN) begin
      errors++; $display("FAIL drain_busy got ready=%b state=%0d required 0/DRAIN", bus.alu_ready, bus.state_dbg);
    end
    @(posedge clk); #1;
    bus.rsv_valid = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b0 || bus.stall !== 1'b1 || bus.state_dbg !== DRAIN) begin
      errors++; $display("FAIL drain_idle got ready=%b stall=%b state=%0d required 0/1/DRAIN", bus.alu_ready, bus.stall, bus.state_dbg);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pending_dbg !== 15'd0 || bus.stall !== 1'b0 || bus.state_dbg !== RUN) begin
      errors++; $display("FAIL drain_exit got pending=%h stall=%b state=%0d required 0/0/RUN", bus.pending_dbg, bus.stall, bus.state_dbg);
    end
    checks++;
    if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL drain_resume got %b required 1", bus.alu_ready); end
    exp_q.push_back({4'd6, 32'h0000_0066});
    @(posedge clk); #1;
    bus.alu_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_transfer();
    @(posedge clk); #1;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd11; bus.chk_a1 = 4'd11; bus.chk_a2 = 4'd0;
    @(posedge clk); #1;
    bus.rsv_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd10; bus.alu_data = 32'hCAFE_0010;
    @(negedge clk);
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.stall !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got ready=%b stall=%b required 1/1", bus.alu_ready, bus.stall);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL midrst_hold got ready=%b stall=%b required 0/0", bus.alu_ready, bus.stall);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rr_ptr_m = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.we3 !== 1'b0 || bus.a3 !== 4'd0 || bus.wd3 !== '0) begin
        errors++; $display("FAIL midrst_after got we3=%b a3=%0d wd3=%h required 0/0/0", bus.we3, bus.a3, bus.wd3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_hazard();
    test_r15();
    test_flush();
    test_reset_mid_transfer();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL writes_outstanding got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got no completion required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
